ercm_mul_sched: RTL and testbench
=================================

Name: ercm_mul_sched

Overview:
- Round-robin scheduler that shares one combinational 8x8 approximate multiplier (ERCM8 family, 7-bit mask input) among NREQ requesters.
- Arbitrates the requests, registers the operands and the per-requester mask into the multiplier, and captures the 16-bit product.
- Returns the product, tagged with the requester ID, through a credit-checked response FIFO.
- Sits between the requester fabric and the multiplier instance; the multiplier stays outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- FIFO_DEPTH, 4, response FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  8*NREQ  operand A; slice i belongs to requester i.
- req_b  in  8*NREQ  operand B; slice i belongs to requester i.
- cfg_we  in  1  mask register write strobe.
- cfg_id  in  IDW  mask register index.
- cfg_mask  in  7  mask write data.
- mul_a  out  8  registered operand A to the multiplier.
- mul_b  out  8  registered operand B to the multiplier.
- mul_mask  out  7  registered mask to the multiplier.
- mul_p  in  16  combinational product returned by the multiplier.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer accepts the head.
- resp_id  out  IDW  requester ID of the head entry.
- resp_p  out  16  product of the head entry.
- busy  out  1  high when in-flight or FIFO count is nonzero.
- op_cnt  out  16  number of completed issues; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clk edge) sets all of the following to zero:
  - mask_reg[0..NREQ-1], mul_a, mul_b, mul_mask;
  - inflight valid, FIFO pointers and count, op_cnt;
  - req_ready, resp_valid, busy.
- Reset sets the RR pointer to NREQ-1, so requester 0 has first priority.
- Reset asserted mid-operation drops the in-flight product and all FIFO contents; no response is emitted for them.
- Issue condition: space = (fifo_count + inflight) < FIFO_DEPTH.
  - A same-cycle FIFO pop does not add credit.
  - When space=0, req_ready is all zeros.
- Arbitration (combinational):
  - Grant g is the first i with req_valid[i]=1, searching upward from (ptr+1) mod NREQ.
  - req_ready[g]=space; every other bit is 0.
  - A handshake is req_valid[g] & req_ready[g].
- On a handshake:
  - mul_a <= req_a[g]; mul_b <= req_b[g]; mul_mask <= mask_reg[g].
  - inflight <= 1; inflight_id <= g; ptr <= g.
- With no handshake: inflight <= 0, ptr holds, and mul_* hold their values.
- Capture: when inflight=1, {inflight_id, mul_p} is pushed into the FIFO at the next clk edge and op_cnt increments.
  - Issue-to-push latency is 1 cycle.
  - A push never overflows, guaranteed by the credit rule.
- Issue rate: one operation per cycle while space holds, i.e. back-to-back issue is allowed.
- Response port:
  - resp_valid = (fifo_count != 0).
  - resp_id and resp_p show the head entry.
  - Pop on resp_valid & resp_ready.
  - The head stays stable while resp_ready=0.
  - Simultaneous push and pop leave count unchanged; both pointers advance modulo FIFO_DEPTH.
- Minimum latency: request handshake at cycle N gives resp_valid=1 at cycle N+2.
- Responses leave in issue order.
- Config write: mask_reg[cfg_id] <= cfg_mask on cfg_we.
  - If the same cycle issues for requester cfg_id, the issue uses the old mask value and the new value applies from the next issue.
  - cfg_id >= NREQ is ignored.
- busy = inflight | (fifo_count != 0).

Test Plan:
- Reset then a single request. Tie mul_p to an exact a*b model, set mask_reg[1]=7'h55, requester 1 sends a=8'd13, b=8'd11 at cycle N. Required: mul_mask=7'h55 at N+1; resp_valid at N+2 with resp_id=1, resp_p=16'd143; op_cnt=1.
- Round robin: all 4 req_valid held high with resp_ready=1. Required: grants 0,1,2,3,0,1 on consecutive cycles; responses arrive in the same ID order, one per cycle.
- Backpressure: resp_ready=0 with requester 2 streaming. Required: exactly 4 issues, then req_ready=0. Releasing resp_ready for 1 cycle lets exactly 1 new issue through (credit appears the cycle after the pop). resp_p values are unchanged while stalled.
- Config/issue collision: mask_reg[0]=7'h00; in one cycle cfg_we with cfg_id=0, cfg_mask=7'h7F, and an issue from requester 0. Required: that issue uses mul_mask=7'h00; the next issue from requester 0 uses 7'h7F.
- Reset mid-flight: with 3 FIFO entries and inflight=1, pulse rst for 1 cycle. Required: the next cycle shows resp_valid=0, busy=0, op_cnt=0, mul_a=0. The first post-reset grant goes to requester 0 when all request.
- Saturation: force 65537 issues, using a=8'hFF, b=8'hFF with resp_ready=1. Required: op_cnt holds 16'hFFFF; every resp_p equals 16'hFE01.

Source files
------------

// File: rtl/ercm_mul_sched.sv
// Round-robin scheduler sharing one external combinational 8x8 approximate
// multiplier among NREQ requesters. Winning operands and the requester's mask
// are registered toward the multiplier. The product is captured one cycle
// later into a credit-checked response FIFO, tagged with the requester ID.
module ercm_mul_sched #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [8*NREQ-1:0]     req_a,
  input  logic [8*NREQ-1:0]     req_b,
  input  logic                  cfg_we,
  input  logic [IDW-1:0]        cfg_id,
  input  logic [6:0]            cfg_mask,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  output logic [6:0]            mul_mask,
  input  logic [15:0]           mul_p,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [15:0]           resp_p,
  output logic                  busy,
  output logic [15:0]           op_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [6:0]     mask_reg [NREQ];
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] inflight_id;
  logic           found;
  logic           space;
  logic           handshake;
  logic           inflight;
  logic           push;
  logic           pop;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic [IDW-1:0] fifo_id [FIFO_DEPTH];
  logic [15:0]    fifo_p  [FIFO_DEPTH];

  // Round-robin search: first valid requester strictly after the last grant.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Credit counts the in-flight product too; a pop in this cycle frees
  // nothing until the count has actually dropped.
  assign space     = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < DEPTH_C;
  assign handshake = found & space;
  assign push      = inflight;
  assign pop       = resp_valid & resp_ready;

  // One-hot grant, gated by credit.
  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant] = 1'b1;
  end

  // Issue stage: register operands and mask toward the multiplier.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr         <= IDW'(NREQ - 1);
      inflight    <= 1'b0;
      inflight_id <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_mask    <= '0;
    end else begin
      inflight <= handshake;
      if (handshake) begin
        mul_a       <= req_a[8*grant +: 8];
        mul_b       <= req_b[8*grant +: 8];
        mul_mask    <= mask_reg[grant];
        inflight_id <= grant;
        ptr         <= grant;
      end
    end
  end

  // Per-requester mask registers; an issue in the same cycle sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) mask_reg[i] <= '0;
    end else if (cfg_we && (int'(cfg_id) < NREQ)) begin
      mask_reg[cfg_id] <= cfg_mask;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries are only visible
    // through fifo_count, which is reset.
    if (push) begin
      fifo_id[wr_ptr] <= inflight_id;
      fifo_p[wr_ptr]  <= mul_p;
    end
  end

  // FIFO pointers, occupancy and saturating completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      op_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && (op_cnt != 16'hFFFF)) op_cnt <= op_cnt + 1'b1;
    end
  end

  assign resp_valid = (fifo_count != '0);
  assign resp_id    = fifo_id[rd_ptr];
  assign resp_p     = fifo_p[rd_ptr];
  assign busy       = inflight | resp_valid;

endmodule

// File: tb/tb_ercm_mul_sched.sv
// Testbench for ercm_mul_sched: transaction-level model (queue of pending
// responses, credit count, rotating priority) compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ercm_mul_sched;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic                cfg_we;
  logic [IDW-1:0]      cfg_id;
  logic [6:0]          cfg_mask;
  logic [7:0]          mul_a;
  logic [7:0]          mul_b;
  logic [6:0]          mul_mask;
  logic [15:0]         mul_p;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [15:0]         resp_p;
  logic                busy;
  logic [15:0]         op_cnt;

  ercm_mul_sched #(.NREQ(NREQ), .IDW(IDW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_p(resp_p),
    .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: exact product.
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      if (errors >= 100) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int id; logic [15:0] p; } resp_t;
  resp_t       m_q[$];
  int          m_ptr;
  bit          m_inf;
  int          m_inf_id;
  logic [7:0]  m_a, m_b;
  logic [6:0]  m_mask;
  logic [6:0]  m_mreg [NREQ];
  int          m_ops;
  bit          chk_en = 0;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0 && (m_q.size() + int'(m_inf)) < DEPTH) exp_ready[g] = 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [NREQ-1:0] rdy;
    int g;
    if (rst) begin
      m_ptr = NREQ - 1; m_inf = 0; m_inf_id = 0;
      m_a = '0; m_b = '0; m_mask = '0; m_ops = 0;
      foreach (m_mreg[i]) m_mreg[i] = '0;
      m_q.delete();
      chk_en = 1;
    end else begin
      rdy = exp_ready();
      g   = pick(req_valid, m_ptr);
      if (m_q.size() != 0 && resp_ready) void'(m_q.pop_front());
      if (m_inf) begin
        m_q.push_back('{m_inf_id, 16'(m_a) * 16'(m_b)});
        if (m_ops < 65535) m_ops++;
      end
      if (rdy != '0) begin
        m_a = req_a[8*g +: 8]; m_b = req_b[8*g +: 8]; m_mask = m_mreg[g];
        m_inf = 1; m_inf_id = g; m_ptr = g;
      end else begin
        m_inf = 0;
      end
      if (cfg_we && int'(cfg_id) < NREQ) m_mreg[cfg_id] = cfg_mask;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready()));
      check("resp_valid", 32'(resp_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("resp_id", 32'(resp_id), 32'(m_q[0].id));
        check("resp_p", 32'(resp_p), 32'(m_q[0].p));
      end
      check("busy", 32'(busy), 32'(m_inf || m_q.size() != 0));
      check("op_cnt", 32'(op_cnt), 32'(m_ops));
      check("mul_a", 32'(mul_a), 32'(m_a));
      check("mul_b", 32'(mul_b), 32'(m_b));
      check("mul_mask", 32'(mul_mask), 32'(m_mask));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int issues;
    logic [15:0] held;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    cfg_we = 1'b0; cfg_id = '0; cfg_mask = '0; resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_mask", 32'(mul_mask), 32'd0);

    // Single request from requester 1 with mask 7'h55.
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_mask = 7'h55;
    tick();
    cfg_we = 1'b0;
    req_a[15:8] = 8'd13; req_b[15:8] = 8'd11; req_valid = 4'b0010;
    #1 check("t1_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #1;
    check("t1_mul_mask", 32'(mul_mask), 32'h55);
    check("t1_mul_a", 32'(mul_a), 32'd13);
    check("t1_resp_early", 32'(resp_valid), 32'd0);
    tick();
    #1;
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_id", 32'(resp_id), 32'd1);
    check("t1_resp_p", 32'(resp_p), 32'd143);
    check("t1_op_cnt", 32'(op_cnt), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1 check("t1_drained", 32'(busy), 32'd0);

    // Round robin with all requesters active.
    rst = 1'b1; tick(); rst = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_a = $urandom; req_b = $urandom; req_valid = 4'hF;
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("rr_resp_valid", 32'(resp_valid), 32'd1);
        check("rr_resp_id", 32'(resp_id), 32'((c - 2) % 4));
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure with requester 2 streaming.
    resp_ready = 1'b0; req_valid = 4'b0100; issues = 0;
    for (int c = 0; c < 8; c++) begin
      req_a[23:16] = 8'($urandom); req_b[23:16] = 8'($urandom);
      #1 if (req_ready[2]) issues++;
      tick();
    end
    check("bp_issues", 32'(issues), 32'd4);
    check("bp_stalled_ready", 32'(req_ready), 32'd0);
    held = resp_p;
    tick(); tick();
    check("bp_head_stable", 32'(resp_p), 32'(held));
    resp_ready = 1'b1;
    #1 check("bp_pop_no_credit", 32'(req_ready), 32'd0);
    tick();
    resp_ready = 1'b0; issues = 0;
    for (int c = 0; c < 5; c++) begin
      #1 if (req_ready[2]) issues++;
      tick();
    end
    check("bp_one_more", 32'(issues), 32'd1);
    req_valid = '0; resp_ready = 1'b1;
    repeat (6) tick();

    // Config write colliding with an issue from requester 0.
    cfg_we = 1'b1; cfg_id = 2'd0; cfg_mask = 7'h00;
    tick();
    cfg_mask = 7'h7F; req_valid = 4'b0001;
    #1 check("cc_grant", 32'(req_ready), 32'b0001);
    tick();
    cfg_we = 1'b0;
    #1 check("cc_old_mask", 32'(mul_mask), 32'h00);
    tick();
    req_valid = '0;
    #1 check("cc_new_mask", 32'(mul_mask), 32'h7F);
    repeat (4) tick();

    // Reset with three FIFO entries and one in flight.
    resp_ready = 1'b0; req_valid = 4'b0001;
    repeat (4) tick();
    #1;
    check("mf_pre_valid", 32'(resp_valid), 32'd1);
    check("mf_pre_busy", 32'(busy), 32'd1);
    req_valid = 4'hF; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mf_resp_valid", 32'(resp_valid), 32'd0);
    check("mf_busy", 32'(busy), 32'd0);
    check("mf_op_cnt", 32'(op_cnt), 32'd0);
    check("mf_mul_a", 32'(mul_a), 32'd0);
    check("mf_first_grant", 32'(req_ready), 32'b0001);
    req_valid = '0; resp_ready = 1'b1;
    tick();

    // Randomized traffic, checked every cycle by the model.
    repeat (3000) begin
      req_valid  = NREQ'($urandom);
      req_a      = $urandom;
      req_b      = $urandom;
      resp_ready = ($urandom % 4) != 0;
      cfg_we     = ($urandom % 8) == 0;
      cfg_id     = IDW'($urandom);
      cfg_mask   = 7'($urandom);
      tick();
    end
    cfg_we = 1'b0; req_valid = '0; resp_ready = 1'b1;
    repeat (6) tick();

    // Saturation of the completion counter.
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = {NREQ{8'hFF}}; req_b = {NREQ{8'hFF}};
    req_valid = 4'hF; resp_ready = 1'b1;
    repeat (65545) tick();
    #1;
    check("sat_op_cnt", 32'(op_cnt), 32'hFFFF);
    check("sat_resp_p", 32'(resp_p), 32'hFE01);
    check("sat_resp_valid", 32'(resp_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
